// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encodings, fault codes and timer width for the fetch sequencer.
package cpu_pkg;
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_WAIT    = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_e;
    localparam logic [1:0] F_NONE     = 2'd0;
    localparam logic [1:0] F_ILLEGAL  = 2'd1;
    localparam logic [1:0] F_TIMEOUT  = 2'd2;
    localparam logic [1:0] F_MISALIGN = 2'd3;
    localparam int TW = 8;
endpackage

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: instruction-memory read handshake between the sequencer and memory.
interface fetch_seq_if #(
    parameter int AW = 14
);
    logic          o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic          i_mem_ack;
    logic [31:0]   i_mem_rdata;
    modport master(output o_mem_req, o_mem_addr, input i_mem_ack, i_mem_rdata);
    modport slave(input o_mem_req, o_mem_addr, output i_mem_ack, i_mem_rdata);
endinterface

// File: rtl/wait_timer.sv
// wait_timer: counts wait cycles; expired flags the cycle whose increment would reach the limit.
module wait_timer
    import cpu_pkg::*;
#(
    parameter int W = TW
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_limit,
    output logic         o_expired
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = i_clear ? '0 : i_enable ? cnt_q + W'(1) : cnt_q;
    assign o_expired = cnt_q == i_limit - W'(1);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: single-issue fetch/decode/execute sequencer with memory timeout and fault halting.
module fetch_seq
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              AW       = 14,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    fetch_seq_if.master     mem,
    output logic [31:0]     o_insn,
    output logic            o_insn_valid,
    input  logic            i_illegal,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_dst,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_gpr_we,
    output logic [4:0]      o_gpr_waddr,
    output logic [XLEN-1:0] o_gpr_wdata,
    output logic [XLEN-1:0] o_pc,
    output logic [2:0]      o_state,
    output logic            o_halted,
    output logic [1:0]      o_fault,
    output logic [31:0]     o_retired,
    input  logic            i_resume
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     insn_q, insn_d, retired_q, retired_d;
    logic [1:0]      fault_q, fault_d;
    logic            tmr_clr, tmr_en, tmr_exp, misalign;

    wait_timer u_timer (
        .i_clk,
        .i_rst_n,
        .i_clear  (tmr_clr),
        .i_enable (tmr_en),
        .i_limit  (TW'(TIMEOUT)),
        .o_expired(tmr_exp)
    );

    assign misalign = i_redirect && (i_redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        insn_d       = insn_q;
        fault_d      = fault_q;
        retired_d    = retired_q;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        o_insn_valid = 1'b0;
        o_gpr_we     = 1'b0;
        o_halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                tmr_clr = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem.i_mem_ack) begin
                    insn_d  = mem.i_mem_rdata;
                    state_d = S_DECODE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_exp) begin
                        state_d = S_HALT;
                        fault_d = F_TIMEOUT;
                    end
                end
            end
            S_DECODE: begin
                o_insn_valid = 1'b1;
                state_d      = i_illegal ? S_HALT : S_EXECUTE;
                fault_d      = i_illegal ? F_ILLEGAL : fault_q;
            end
            S_EXECUTE: begin
                // A misaligned target faults the instruction: no write, no retire, pc kept.
                o_gpr_we  = i_wb_en && (i_wb_dst != 5'd0) && !misalign;
                state_d   = misalign ? S_HALT : S_FETCH;
                fault_d   = misalign ? F_MISALIGN : fault_q;
                pc_d      = misalign ? pc_q : i_redirect ? i_redirect_pc : pc_q + XLEN'(4);
                retired_d = misalign ? retired_q : retired_q + 32'd1;
            end
            S_HALT: begin
                o_halted = 1'b1;
                if (i_resume) begin
                    state_d = S_FETCH;
                    pc_d    = RESET_PC;
                    fault_d = F_NONE;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            insn_q    <= '0;
            fault_q   <= F_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            insn_q    <= insn_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    // Reset sits in FETCH, so the request is masked while reset is held.
    assign mem.o_mem_req  = i_rst_n && (state_q == S_FETCH || state_q == S_WAIT);
    assign mem.o_mem_addr = pc_q[AW+1:2];
    assign o_insn         = insn_q;
    assign o_gpr_waddr    = i_wb_dst;
    assign o_gpr_wdata    = i_wb_data;
    assign o_pc           = pc_q;
    assign o_state        = state_q;
    assign o_fault        = fault_q;
    assign o_retired      = retired_q;
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed instruction stream checked cycle-by-cycle against a transaction-level trace model.
module tb_fetch_seq;
    localparam int XLEN = 64;
    localparam int AW   = 14;
    localparam int TMO  = 4;

    typedef struct {
        logic ack; logic [31:0] rdata; logic ill; logic wen; logic [4:0] dst; logic [63:0] wd;
        logic redir; logic [63:0] rpc; logic resume;
        int st; logic req; logic [AW-1:0] addr; logic [31:0] insn; logic valid; logic we;
        logic halted; logic [1:0] fault; logic [31:0] retired; logic [63:0] pc;
    } cyc_t;

    logic clk = 1'b0, rst_n;
    logic illegal, wb_en, redirect, resume, gpr_we, insn_valid, halted;
    logic [4:0] wb_dst, gpr_waddr;
    logic [63:0] wb_data, redirect_pc, gpr_wdata, pc;
    logic [31:0] insn, retired;
    logic [2:0] state;
    logic [1:0] fault;
    always #5 clk = ~clk;

    fetch_seq_if #(.AW(AW)) bus ();

    fetch_seq #(.XLEN(XLEN), .AW(AW), .RESET_PC(64'h0), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .mem(bus),
        .o_insn(insn), .o_insn_valid(insn_valid), .i_illegal(illegal),
        .i_wb_en(wb_en), .i_wb_dst(wb_dst), .i_wb_data(wb_data),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_gpr_we(gpr_we), .o_gpr_waddr(gpr_waddr), .o_gpr_wdata(gpr_wdata),
        .o_pc(pc), .o_state(state), .o_halted(halted), .o_fault(fault),
        .o_retired(retired), .i_resume(resume)
    );

    int n_cmp = 0, n_err = 0, req_cnt, dec_at;
    cyc_t q[$];
    logic [63:0] m_pc;
    logic [31:0] m_retired, m_insn;
    logic [1:0]  m_fault;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic cyc_t mk(int st);
        cyc_t c;
        c.ack = 0; c.rdata = $urandom; c.ill = 0; c.wen = 0; c.dst = 0; c.wd = 0;
        c.redir = 0; c.rpc = 0; c.resume = 0;
        c.st = st; c.req = (st == 0 || st == 1); c.addr = m_pc[AW+1:2]; c.insn = m_insn;
        c.valid = (st == 2); c.we = 0; c.halted = (st == 4); c.fault = m_fault;
        c.retired = m_retired; c.pc = m_pc;
        return c;
    endfunction

    task automatic add_fetch(int d, int nw, logic stray, logic [31:0] word);
        cyc_t c;
        c = mk(0); c.ack = stray; c.resume = stray; q.push_back(c);
        for (int w = 1; w <= nw; w++) begin
            c = mk(1); c.ack = (w == d); c.resume = stray;
            if (w == d) c.rdata = word;
            q.push_back(c);
        end
    endtask

    // d = ack delay in WAIT cycles (0 = never acked)
    task automatic add_insn(int d, logic [31:0] word, logic ill, logic wen, logic [4:0] dst,
                            logic [63:0] wd, logic redir, logic [63:0] tgt, logic stray);
        cyc_t c;
        logic mis;
        if (d == 0 || d > TMO) begin
            add_fetch(0, TMO, stray, word);
            m_fault = 2'd2;
            return;
        end
        add_fetch(d, d, stray, word);
        m_insn = word;
        c = mk(2); c.ill = ill; c.resume = stray; q.push_back(c);
        if (ill) begin
            m_fault = 2'd1;
            return;
        end
        mis = redir && tgt[1:0] != 2'b00;
        c = mk(3); c.wen = wen; c.dst = dst; c.wd = wd; c.redir = redir; c.rpc = tgt;
        c.resume = stray; c.we = wen && dst != 0 && !mis; q.push_back(c);
        if (mis) m_fault = 2'd3;
        else begin
            m_pc = redir ? tgt : m_pc + 64'd4;
            m_retired++;
        end
    endtask

    task automatic add_halt(int n, logic res);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = mk(4); c.resume = res && (i == n - 1); q.push_back(c);
        end
        if (res) begin
            m_pc = 64'h0;
            m_fault = 2'd0;
        end
    endtask

    task automatic idle();
        bus.i_mem_ack = 0; bus.i_mem_rdata = 0; illegal = 0; wb_en = 0; wb_dst = 0; wb_data = 0;
        redirect = 0; redirect_pc = 0; resume = 0;
    endtask

    task automatic run();
        int idx;
        idx = 0; req_cnt = 0; dec_at = -1;
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            bus.i_mem_ack = c.ack; bus.i_mem_rdata = c.rdata; illegal = c.ill; wb_en = c.wen;
            wb_dst = c.dst; wb_data = c.wd; redirect = c.redir; redirect_pc = c.rpc; resume = c.resume;
            @(negedge clk);
            req_cnt += int'(bus.o_mem_req);
            if (insn_valid && dec_at < 0) dec_at = idx;
            chk("state", state, c.st);
            chk("mem_req", bus.o_mem_req, c.req);
            chk("mem_addr", bus.o_mem_addr, c.addr);
            chk("insn", insn, c.insn);
            chk("insn_valid", insn_valid, c.valid);
            chk("gpr_we", gpr_we, c.we);
            chk("halted", halted, c.halted);
            chk("fault", fault, c.fault);
            chk("retired", retired, c.retired);
            chk("pc", pc, c.pc);
            if (c.we) begin
                chk("gpr_waddr", gpr_waddr, c.dst);
                chk("gpr_wdata", gpr_wdata, c.wd);
            end
            idx++;
            @(posedge clk); #1;
        end
        idle();
    endtask

    initial begin
        rst_n = 0; idle();
        m_pc = 0; m_retired = 0; m_insn = 0; m_fault = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", state, 0); chk("rst_req", bus.o_mem_req, 0); chk("rst_insn", insn, 0);
        chk("rst_we", gpr_we, 0); chk("rst_halted", halted, 0); chk("rst_fault", fault, 0);
        chk("rst_retired", retired, 0); chk("rst_pc", pc, 0);
        @(posedge clk); #1;
        rst_n = 1;
        // zero-wait fetch of a nop
        add_insn(1, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0); run();
        chk("A_decode_cycle", dec_at, 2); chk("A_pc", pc, 64'd4); chk("A_retired", retired, 1);
        chk("A_insn", insn, 32'h0000_0013);
        // ack after 3 cycles, stray ack in FETCH, write to x0
        add_insn(3, 32'hDEAD_BEEF, 0, 1, 0, 64'h1234, 0, 0, 1); run();
        chk("B_req_cycles", req_cnt, 4); chk("B_insn", insn, 32'hDEAD_BEEF);
        // write x5 and branch to 0x100
        add_insn(1, 32'h0000_0293, 0, 1, 5, 64'hDEAD, 1, 64'h100, 0); run();
        chk("C_addr", bus.o_mem_addr, 14'h40); chk("C_pc", pc, 64'h100); chk("C_retired", retired, 3);
        // misaligned redirect
        add_insn(2, 32'h0000_0063, 0, 1, 7, 64'h55, 1, 64'h102, 0); run();
        chk("D_state", state, 4); chk("D_fault", fault, 3); chk("D_retired", retired, 3);
        chk("D_halted", halted, 1); chk("D_pc", pc, 64'h100);
        add_halt(3, 1); run();
        chk("D_resume_state", state, 0); chk("D_resume_pc", pc, 0); chk("D_resume_fault", fault, 0);
        // timeout
        add_insn(0, 0, 0, 0, 0, 0, 0, 0, 0); run();
        chk("E_fault", fault, 2); chk("E_req", bus.o_mem_req, 0); chk("E_state", state, 4);
        chk("E_req_cycles", req_cnt, 5);
        add_halt(2, 1); run();
        chk("E_resume_pc", pc, 0);
        // illegal
        add_insn(1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0); run();
        chk("F_fault", fault, 1); chk("F_retired", retired, 3);
        add_halt(1, 1); run();
        // pc wrap at 2^XLEN
        add_insn(1, 32'h1, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        add_insn(2, 32'h2, 0, 0, 0, 0, 0, 0, 0); run();
        chk("J_wrap_pc", pc, 0); chk("J_retired", retired, 5);
        // ack on the last allowed WAIT cycle
        add_insn(TMO, 32'h0040_0093, 0, 1, 1, 64'h7, 0, 0, 0); run();
        chk("G_retired", retired, 6); chk("G_insn", insn, 32'h0040_0093); chk("G_pc", pc, 4);
        // reset mid-WAIT
        add_fetch(0, 2, 0, 0); run();
        #2 rst_n = 0;
        #1;
        chk("mid_state", state, 0); chk("mid_req", bus.o_mem_req, 0); chk("mid_pc", pc, 0);
        chk("mid_insn", insn, 0); chk("mid_retired", retired, 0); chk("mid_fault", fault, 0);
        chk("mid_halted", halted, 0); chk("mid_we", gpr_we, 0);
        bus.i_mem_ack = 1; bus.i_mem_rdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        chk("late_ack_insn", insn, 0); chk("late_ack_state", state, 0);
        rst_n = 1;
        m_pc = 0; m_retired = 0; m_insn = 0; m_fault = 0;
        add_insn(1, 32'h0010_0093, 0, 0, 0, 0, 0, 0, 1); run();
        chk("H_retired", retired, 1); chk("H_pc", pc, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the PC and register data width.
REQ-002 SHALL have parameter AW, default 14, meaning the word-address width of instruction memory.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the byte PC loaded at reset.
REQ-004 SHALL have parameter TIMEOUT, default 15, meaning the maximum wait cycles for a memory ack (range 1..255).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 i_clk  input  1  clock; all state changes on the rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 o_mem_req  output  1  instruction read request, held high until ack.
REQ-009 o_mem_addr  output  AW  word address, equal to pc[AW+1:2].
REQ-010 i_mem_ack  input  1  read data valid this cycle.
REQ-011 i_mem_rdata  input  32  instruction word.
REQ-012 o_insn  output  32  latched instruction, fed to the decoder.
REQ-013 o_insn_valid  output  1  high for exactly the DECODE cycle.
REQ-014 i_illegal  input  1  decoder flags an illegal instruction (sampled in DECODE).
REQ-015 i_wb_en, i_wb_dst[4:0], i_wb_data[XLEN]  input  write-back request from the ALU (sampled in EXECUTE).
REQ-016 i_redirect, i_redirect_pc[XLEN]  input  taken branch and target (sampled in EXECUTE).
REQ-017 o_gpr_we, o_gpr_waddr[4:0], o_gpr_wdata[XLEN]  output  register-file write port.
REQ-018 o_pc  output  XLEN  address of the instruction in flight.
REQ-019 o_state  output  3  current state encoding.
REQ-020 o_halted, o_fault[1:0], o_retired[31:0]  output  halt flag, fault cause, retired-instruction count.
REQ-021 i_resume  input  1  leave HALT and restart at RESET_PC.

Function
REQ-022 SHALL implement states FETCH=0, WAIT=1, DECODE=2, EXECUTE=3, HALT=4.
REQ-023 FETCH: assert o_mem_req and clear the wait counter, then go to WAIT unconditionally.
REQ-024 WAIT: keep o_mem_req high; on i_mem_ack latch i_mem_rdata into o_insn, drop the request and go to DECODE.
REQ-025 WAIT, no ack: increment the counter; when the counter reaches TIMEOUT without an ack, go to HALT with o_fault=2'd2.
REQ-026 Zero-wait memory (ack in the first WAIT cycle) SHALL give fetch-to-DECODE latency of 2 cycles.
REQ-027 DECODE: if i_illegal, go to HALT with o_fault=2'd1; otherwise go to EXECUTE.
REQ-028 EXECUTE: o_gpr_we = i_wb_en && (i_wb_dst != 0), so writes to x0 are suppressed.
REQ-029 EXECUTE: next pc = i_redirect ? i_redirect_pc : pc+4 (wraps modulo 2^XLEN).
REQ-030 EXECUTE: increment o_retired (wraps at 2^32), then go to FETCH.
REQ-031 A redirect target with pc[1:0] != 0 SHALL go to HALT with o_fault=2'd3, without retiring and without a register write.
REQ-032 HALT: o_halted=1, no memory request, pc frozen.
REQ-033 In HALT, i_resume SHALL load RESET_PC, clear o_fault and go to FETCH; o_retired is kept.
REQ-034 An ack arriving outside WAIT SHALL be ignored.
REQ-035 i_resume outside HALT SHALL be ignored.

Reset
REQ-036 Asserting i_rst_n low, at any point including mid-WAIT, SHALL immediately set: state=FETCH, pc=RESET_PC, o_mem_req=0, o_insn=0, o_gpr_we=0, o_halted=0, o_fault=0, o_retired=0, wait counter=0.
REQ-037 The first request SHALL appear in the first cycle after reset is released.

Structure
REQ-038 State encodings and fault codes SHALL live in the shared package cpu_pkg, which replaces the standalone state-include file.
REQ-039 The timeout counter SHALL be a sub-module named wait_timer (clear, enable, limit, expired).

Verification
REQ-040 Zero-wait memory, word at address 0 = 0x00000013, no redirect -> DECODE at cycle 2, o_pc=4 after EXECUTE, o_retired=1.
REQ-041 Ack delayed 3 cycles -> o_mem_req high for exactly 4 cycles, o_insn latched on the ack cycle only.
REQ-042 TIMEOUT=4 with no ack -> HALT after 4 WAIT cycles, o_fault=2, o_mem_req=0; i_resume -> FETCH with pc=RESET_PC.
REQ-043 i_wb_en=1, i_wb_dst=0 -> o_gpr_we=0; i_wb_dst=5, data 0xDEAD -> o_gpr_we=1, waddr 5, wdata 0xDEAD.
REQ-044 Redirect to 0x100 -> next o_mem_addr=0x40; redirect to 0x102 -> o_fault=3, o_retired unchanged.
REQ-045 Reset pulsed mid-WAIT -> all outputs return to reset values in the same cycle; a late ack is ignored.
